// File: rtl/huff_encoder.sv
// Three-symbol Huffman code generator: loads {freq, char} triples, builds the
// two-level code tree, then streams each character followed by its mask/value word.
module huff_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);

  // state     | meaning
  // ST_IDLE   | waiting for / capturing the three input entries
  // ST_SORT   | pick the heaviest leaf T and order the remaining pair X, Y
  // ST_MERGE  | X and Y become one internal node; root = {T, node}
  // ST_ENCODE | derive per-slot mask/value from the tree shape
  // ST_OUTPUT | stream char/code words for slots 0..2
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SORT,
    ST_MERGE,
    ST_ENCODE,
    ST_OUTPUT
  } state_t;

  state_t state, state_nx;

  logic       in_valid;
  logic [2:0] in_freq;
  logic [7:0] in_char;

  logic [1:0] load_cnt;
  logic [2:0] out_cnt;

  logic [2:0] slot_freq [3];
  logic [7:0] slot_char [3];

  // sort results
  logic [1:0] t_sel, x_sel, y_sel;
  logic [1:0] pair_lo, pair_hi;
  logic [2:0] t_freq;
  logic [1:0] t_idx, x_idx, y_idx;

  // tree after merge
  logic [1:0] root_leaf, node_left, node_right;

  logic [2:0] code_mask [3];
  logic [2:0] code_val  [3];

  logic [1:0]  out_slot;
  logic [11:0] out_word;

  assign in_valid = io_in[11];
  assign in_freq  = io_in[10:8];
  assign in_char  = io_in[7:0];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (in_valid && (load_cnt == 2'd2)) state_nx = ST_SORT;
      ST_SORT:   state_nx = ST_MERGE;
      ST_MERGE:  state_nx = ST_ENCODE;
      ST_ENCODE: state_nx = ST_OUTPUT;
      ST_OUTPUT: if (out_cnt == 3'd5) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Strict '>' keeps ties on the lower index for both T and X.
  always_comb begin
    t_sel  = 2'd0;
    t_freq = slot_freq[0];
    if (slot_freq[1] > t_freq) begin
      t_sel  = 2'd1;
      t_freq = slot_freq[1];
    end
    if (slot_freq[2] > t_freq) begin
      t_sel  = 2'd2;
      t_freq = slot_freq[2];
    end
    case (t_sel)
      2'd0:    begin pair_lo = 2'd1; pair_hi = 2'd2; end
      2'd1:    begin pair_lo = 2'd0; pair_hi = 2'd2; end
      default: begin pair_lo = 2'd0; pair_hi = 2'd1; end
    endcase
    if (slot_freq[pair_hi] > slot_freq[pair_lo]) begin
      x_sel = pair_hi;
      y_sel = pair_lo;
    end else begin
      x_sel = pair_lo;
      y_sel = pair_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        slot_freq[i] <= 3'd0;
        slot_char[i] <= 8'd0;
      end
    end else if (state == ST_IDLE && in_valid) begin
      slot_freq[load_cnt] <= in_freq;
      slot_char[load_cnt] <= in_char;
      load_cnt            <= (load_cnt == 2'd2) ? 2'd0 : load_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_idx      <= 2'd0;
      x_idx      <= 2'd0;
      y_idx      <= 2'd0;
      root_leaf  <= 2'd0;
      node_left  <= 2'd0;
      node_right <= 2'd0;
    end else begin
      if (state == ST_SORT) begin
        t_idx <= t_sel;
        x_idx <= x_sel;
        y_idx <= y_sel;
      end
      if (state == ST_MERGE) begin
        root_leaf  <= t_idx;
        node_left  <= x_idx;
        node_right <= y_idx;
      end
    end
  end

  // Root's leaf sits on branch '1'; inside the node X takes '1', Y takes '0'.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        code_mask[i] <= 3'd0;
        code_val[i]  <= 3'd0;
      end
    end else if (state == ST_ENCODE) begin
      for (int i = 0; i < 3; i++) begin
        if (root_leaf == 2'(i)) begin
          code_mask[i] <= 3'b001;
          code_val[i]  <= 3'b001;
        end else if (node_left == 2'(i)) begin
          code_mask[i] <= 3'b011;
          code_val[i]  <= 3'b001;
        end else if (node_right == 2'(i)) begin
          code_mask[i] <= 3'b011;
          code_val[i]  <= 3'b000;
        end else begin
          code_mask[i] <= 3'b000;
          code_val[i]  <= 3'b000;
        end
      end
    end
  end

  assign out_slot = out_cnt[2:1];

  always_comb begin
    out_word = 12'd0;
    if (out_cnt[0])
      out_word = {3'b000, 1'b1, 2'b00, code_mask[out_slot], code_val[out_slot]};
    else
      out_word = {3'b000, 1'b1, slot_char[out_slot]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt <= 3'd0;
      io_out  <= 12'd0;
    end else begin
      if (state == ST_OUTPUT) begin
        io_out  <= out_word;
        out_cnt <= out_cnt + 3'd1;
      end else begin
        io_out  <= 12'd0;
        out_cnt <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_huff_encoder.sv
// Directed bench for huff_encoder: hand-computed 6-word sequences per vector,
// latency, gaps, back-to-back vectors and reset abort.
module tb_huff_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] io_in;
  logic [11:0] io_out;

  int total = 0;
  int bad   = 0;

  logic [11:0] cap [10];

  localparam logic [8:0] C1  = 9'h109;
  localparam logic [8:0] C01 = 9'h119;
  localparam logic [8:0] C00 = 9'h118;

  huff_encoder dut (
    .clk    (clk),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic load_vec(input logic [2:0] f0, input logic [7:0] c0,
                          input logic [2:0] f1, input logic [7:0] c1,
                          input logic [2:0] f2, input logic [7:0] c2,
                          input int gap);
    logic [10:0] w [3];
    w[0] = {f0, c0};
    w[1] = {f1, c1};
    w[2] = {f2, c2};
    for (int i = 0; i < 3; i++) begin
      io_in = {1'b1, w[i]};
      @(posedge clk); #1;
      if (i < 2) begin
        io_in = 12'h000;
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
    io_in = 12'h000;
  endtask

  // cap[j] holds io_out just after edge E+1+j; optional junk valid words
  // are presented while the block is busy and removed before edge E+10.
  task automatic capture(input bit noise);
    io_in = noise ? 12'hFFF : 12'h000;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      cap[j] = io_out;
      if (noise && j < 8) io_in = {1'b1, 3'(j), 8'h40 + 8'(j)};
      else                io_in = 12'h000;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_in = 12'hFAB;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (io_out !== 12'h000) begin
        bad++;
        $display("FAIL reset_hold%0d got=%h want=000", i, io_out);
      end
    end
    io_in = 12'h000;
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if (io_out !== 12'h000) begin
        bad++;
        $display("FAIL reset_idle got=%h want=000", io_out);
      end
    end
  endtask

  task automatic test_basic();
    logic [8:0] exp [6];
    exp = '{9'h161, C1, 9'h16E, C01, 9'h16D, C00};
    load_vec(3'd4, 8'h61, 3'd2, 8'h6E, 3'd2, 8'h6D, 0);
    capture(1'b0);
    for (int j = 0; j < 3; j++) begin
      total++;
      if (cap[j] !== 12'h000) begin
        bad++;
        $display("FAIL basic_latency%0d got=%h want=000", j, cap[j]);
      end
    end
    for (int j = 0; j < 6; j++) begin
      total++;
      if (cap[3+j] !== {3'b000, exp[j]}) begin
        bad++;
        $display("FAIL basic_word%0d got=%h want=%h", j, cap[3+j], {3'b000, exp[j]});
      end
    end
    total++;
    if (cap[9] !== 12'h000) begin
      bad++;
      $display("FAIL basic_tail got=%h want=000", cap[9]);
    end
  endtask

  task automatic test_ignore_busy();
    logic [8:0] exp [6];
    exp = '{9'h178, C00, 9'h179, C1, 9'h17A, C01};
    load_vec(3'd1, 8'h78, 3'd3, 8'h79, 3'd2, 8'h7A, 0);
    capture(1'b1);
    for (int j = 0; j < 6; j++) begin
      total++;
      if (cap[3+j] !== {3'b000, exp[j]}) begin
        bad++;
        $display("FAIL busy_word%0d got=%h want=%h", j, cap[3+j], {3'b000, exp[j]});
      end
    end
    for (int j = 0; j < 10; j++) begin
      if (j < 3 || j == 9) begin
        total++;
        if (cap[j] !== 12'h000) begin
          bad++;
          $display("FAIL busy_quiet%0d got=%h want=000", j, cap[j]);
        end
      end
    end
    // A vector right after must be unaffected by the junk words.
    load_vec(3'd1, 8'h78, 3'd3, 8'h79, 3'd2, 8'h7A, 0);
    capture(1'b0);
    for (int j = 0; j < 6; j++) begin
      total++;
      if (cap[3+j] !== {3'b000, exp[j]}) begin
        bad++;
        $display("FAIL busy_next%0d got=%h want=%h", j, cap[3+j], {3'b000, exp[j]});
      end
    end
  endtask

  task automatic test_gap();
    logic [8:0] exp [6];
    exp = '{9'h167, C01, 9'h168, C00, 9'h169, C1};
    load_vec(3'd5, 8'h67, 3'd1, 8'h68, 3'd6, 8'h69, 3);
    capture(1'b0);
    for (int j = 0; j < 10; j++) begin
      total++;
      if (j >= 3 && j < 9) begin
        if (cap[j] !== {3'b000, exp[j-3]}) begin
          bad++;
          $display("FAIL gap_word%0d got=%h want=%h", j - 3, cap[j], {3'b000, exp[j-3]});
        end
      end else if (cap[j] !== 12'h000) begin
        bad++;
        $display("FAIL gap_quiet%0d got=%h want=000", j, cap[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] fq [5][3];
    logic [7:0] ch [5][3];
    logic [8:0] exp [5][6];
    int         nvalid;
    fq = '{'{3'd4, 3'd2, 3'd2}, '{3'd1, 3'd3, 3'd2}, '{3'd3, 3'd3, 3'd1},
           '{3'd2, 3'd2, 3'd2}, '{3'd0, 3'd0, 3'd7}};
    ch = '{'{8'h61, 8'h6E, 8'h6D}, '{8'h78, 8'h79, 8'h7A}, '{8'h61, 8'h62, 8'h63},
           '{8'h70, 8'h71, 8'h72}, '{8'h41, 8'h42, 8'h43}};
    exp = '{'{9'h161, C1,  9'h16E, C01, 9'h16D, C00},
            '{9'h178, C00, 9'h179, C1,  9'h17A, C01},
            '{9'h161, C1,  9'h162, C01, 9'h163, C00},
            '{9'h170, C1,  9'h171, C01, 9'h172, C00},
            '{9'h141, C01, 9'h142, C00, 9'h143, C1}};
    for (int v = 0; v < 5; v++) begin
      load_vec(fq[v][0], ch[v][0], fq[v][1], ch[v][1], fq[v][2], ch[v][2], 0);
      capture(1'b0);
      nvalid = 0;
      for (int j = 0; j < 10; j++) if (cap[j][8]) nvalid++;
      total++;
      if (nvalid != 6) begin
        bad++;
        $display("FAIL b2b_count v%0d got=%0d want=6", v, nvalid);
      end
      for (int j = 0; j < 6; j++) begin
        total++;
        if (cap[3+j] !== {3'b000, exp[v][j]}) begin
          bad++;
          $display("FAIL b2b_word v%0d w%0d got=%h want=%h", v, j, cap[3+j], {3'b000, exp[v][j]});
        end
      end
      total++;
      if (cap[9] !== 12'h000) begin
        bad++;
        $display("FAIL b2b_tail v%0d got=%h want=000", v, cap[9]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp [6];
    exp = '{9'h161, C1, 9'h16E, C01, 9'h16D, C00};
    load_vec(3'd1, 8'h78, 3'd3, 8'h79, 3'd2, 8'h7A, 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    total++;
    if (io_out !== {3'b000, C00}) begin
      bad++;
      $display("FAIL abort_second_word got=%h want=%h", io_out, {3'b000, C00});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (io_out !== 12'h000) begin
      bad++;
      $display("FAIL abort_out got=%h want=000", io_out);
    end
    reset = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      total++;
      if (io_out !== 12'h000) begin
        bad++;
        $display("FAIL abort_quiet got=%h want=000", io_out);
      end
    end
    // partial load followed by reset must not leave a stale load count
    io_in = {1'b1, 3'd7, 8'h5A};
    @(posedge clk); #1;
    io_in = 12'h000;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    load_vec(3'd4, 8'h61, 3'd2, 8'h6E, 3'd2, 8'h6D, 0);
    capture(1'b0);
    for (int j = 0; j < 6; j++) begin
      total++;
      if (cap[3+j] !== {3'b000, exp[j]}) begin
        bad++;
        $display("FAIL abort_reload%0d got=%h want=%h", j, cap[3+j], {3'b000, exp[j]});
      end
    end
    total++;
    if (cap[2] !== 12'h000 || cap[9] !== 12'h000) begin
      bad++;
      $display("FAIL abort_reload_edges got=%h,%h want=000,000", cap[2], cap[9]);
    end
  endtask

  initial begin
    reset = 1'b1;
    io_in = 12'h000;
    test_reset();
    test_basic();
    test_ignore_busy();
    test_gap();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
